// File: rtl/div_pkg.sv
// Shared types and sizing for the 4-bit signed restoring divider.
package div_pkg;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned ITER_CNT = 4;
  localparam int unsigned CNT_W    = $clog2(ITER_CNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two's-complement magnitude; |-8| stays 4'b1000 as an unsigned value.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/signed_divider_4bit_if.sv
// Request/result bundle for signed_divider_4bit; error flags exist only when DIV_ERR_FLAGS_EN is defined.
interface signed_divider_4bit_if;
  import div_pkg::*;

  logic              start;
  logic [DATA_W-1:0] i_dividend;
  logic [DATA_W-1:0] i_divisor;
  logic [DATA_W-1:0] o_quotient;
  logic [DATA_W-1:0] o_remainder;
  logic              o_busy;
  logic              o_assert_done;
`ifdef DIV_ERR_FLAGS_EN
  logic              o_div_by_zero;
  logic              o_overflow;

  modport master (output start, i_dividend, i_divisor,
                  input  o_quotient, o_remainder, o_busy, o_assert_done,
                         o_div_by_zero, o_overflow);
  modport slave  (input  start, i_dividend, i_divisor,
                  output o_quotient, o_remainder, o_busy, o_assert_done,
                         o_div_by_zero, o_overflow);
`else
  modport master (output start, i_dividend, i_divisor,
                  input  o_quotient, o_remainder, o_busy, o_assert_done);
  modport slave  (input  start, i_dividend, i_divisor,
                  output o_quotient, o_remainder, o_busy, o_assert_done);
`endif

endinterface

// File: rtl/signed_divider_4bit_controller.sv
// Divider sequencer: IDLE/ITER/FIXUP/DONE FSM, step counter, busy/done and datapath enables.
module div_controller
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load_c,
  output logic step_c,
  output logic fix_c
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  // State, counter and registered status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= (state_nx == ITER) || (state_nx == FIXUP);
      done  <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load_c   = 1'b0;
    step_c   = 1'b0;
    fix_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ITER;
          cnt_nx   = '0;
          load_c   = 1'b1;
        end
      end
      ITER: begin
        step_c = 1'b1;
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ITER_CNT - 1)) begin
          state_nx = FIXUP;
          cnt_nx   = '0;
        end
      end
      FIXUP: begin
        fix_c    = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/signed_divider_4bit.sv
// 4-bit signed truncating divider: magnitude restoring loop plus sign fix-up.
// Define DIV_ERR_FLAGS_EN to add divide-by-zero and -8/-1 overflow flags.
module signed_divider_4bit
  import div_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  signed_divider_4bit_if.slave  bus
);

  logic              busy, done, load_c, step_c, fix_c;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic              sgn_dvd, sgn_dvs;
  logic [DATA_W-1:0] quotient, remainder;
  logic [DATA_W-1:0] rem_sh;
  logic [DATA_W:0]   diff;

  div_controller u_ctrl (
    .clk    (i_clk),
    .rst    (i_rst),
    .start  (bus.start),
    .busy   (busy),
    .done   (done),
    .load_c (load_c),
    .step_c (step_c),
    .fix_c  (fix_c)
  );

  // One restoring step: shift {rem, quo} left, trial-subtract with a borrow bit.
  assign rem_sh = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
  assign diff   = {1'b0, rem_sh} - {1'b0, dvs_q};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sgn_dvd   <= 1'b0;
      sgn_dvs   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (load_c) begin
        rem_q   <= '0;
        quo_q   <= mag(bus.i_dividend);
        dvs_q   <= mag(bus.i_divisor);
        sgn_dvd <= bus.i_dividend[DATA_W-1];
        sgn_dvs <= bus.i_divisor[DATA_W-1];
      end
      if (step_c) begin
        if (!diff[DATA_W]) begin
          rem_q <= diff[DATA_W-1:0];
          quo_q <= {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_q <= rem_sh;
          quo_q <= {quo_q[DATA_W-2:0], 1'b0};
        end
      end
      if (fix_c) begin
        quotient  <= (sgn_dvd ^ sgn_dvs) ? -quo_q : quo_q;
        remainder <= sgn_dvd ? -rem_q : rem_q;
      end
    end
  end

  assign bus.o_quotient    = quotient;
  assign bus.o_remainder   = remainder;
  assign bus.o_busy        = busy;
  assign bus.o_assert_done = done;

`ifdef DIV_ERR_FLAGS_EN
  logic dz_l, ov_l, dz_q, ov_q;

  // Flags are captured with the operands and published alongside the results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dz_l <= 1'b0;
      ov_l <= 1'b0;
      dz_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      if (load_c) begin
        dz_l <= (bus.i_divisor == '0);
        ov_l <= (bus.i_dividend == {1'b1, {(DATA_W-1){1'b0}}}) && (bus.i_divisor == '1);
      end
      if (fix_c) begin
        dz_q <= dz_l;
        ov_q <= ov_l;
      end
    end
  end

  assign bus.o_div_by_zero = dz_q;
  assign bus.o_overflow    = ov_q;
`endif

endmodule

// File: tb/tb_signed_divider_4bit.sv
// Directed and exhaustive self-checking bench for signed_divider_4bit (optionally with DIV_ERR_FLAGS_EN).
module tb_signed_divider_4bit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  signed_divider_4bit_if dif ();

  signed_divider_4bit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating signed division; divisor 0 yields magnitude 15 / |dividend| then sign fix-up.
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
    int ia, ib, iq, ir;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) begin
      iq = (ia < 0) ? -15 : 15;
      ir = ia;
    end else begin
      iq = ia / ib;
      ir = ia % ib;
    end
    return {4'(iq), 4'(ir)};
  endfunction

  // Issue one division from IDLE, wait for done (bounded) and return to IDLE.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r,
                        output int lat, output logic shape_ok);
    shape_ok = 1'b1;
    dif.start      = 1'b1;
    dif.i_dividend = a;
    dif.i_divisor  = b;
    @(posedge clk); #1;
    dif.start = 1'b0;
    lat = 0;
    if (dif.o_busy !== 1'b1 || dif.o_assert_done !== 1'b0) shape_ok = 1'b0;
    while (dif.o_assert_done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 5 && dif.o_busy !== 1'b1) shape_ok = 1'b0;
    end
    if (dif.o_busy !== 1'b0) shape_ok = 1'b0;
    q = dif.o_quotient;
    r = dif.o_remainder;
    @(posedge clk); #1;
    if (dif.o_assert_done !== 1'b0) shape_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dif.start      = 1'b1;
    dif.i_dividend = 4'd7;
    dif.i_divisor  = 4'd2;
    @(posedge clk); #1;
    n_tests++; if (dif.o_quotient !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", dif.o_quotient); end
    n_tests++; if (dif.o_remainder !== 4'h0) begin n_fail++; $display("FAIL reset_r: got %h expected 0", dif.o_remainder); end
    n_tests++; if (dif.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", dif.o_busy); end
    n_tests++; if (dif.o_assert_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", dif.o_assert_done); end
`ifdef DIV_ERR_FLAGS_EN
    n_tests++; if ({dif.o_div_by_zero, dif.o_overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", dif.o_div_by_zero, dif.o_overflow); end
`endif
    rst = 1'b0;
    dif.start = 1'b0;
  endtask

  task automatic test_basic;
    logic [3:0] q, r;
    int         lat;
    logic       ok;
    do_div(4'd7, 4'd2, q, r, lat, ok);
    n_tests++; if (q !== 4'b0011) begin n_fail++; $display("FAIL 7/2_q: got %b expected 0011", q); end
    n_tests++; if (r !== 4'b0001) begin n_fail++; $display("FAIL 7/2_r: got %b expected 0001", r); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL 7/2_latency: got %0d expected 5", lat); end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL 7/2_busy_done_shape: got %b expected 1", ok); end
    do_div(4'b1001, 4'd2, q, r, lat, ok);
    n_tests++; if (q !== 4'b1101) begin n_fail++; $display("FAIL -7/2_q: got %b expected 1101", q); end
    n_tests++; if (r !== 4'b1111) begin n_fail++; $display("FAIL -7/2_r: got %b expected 1111", r); end
    do_div(4'd7, 4'b1110, q, r, lat, ok);
    n_tests++; if (q !== 4'b1101) begin n_fail++; $display("FAIL 7/-2_q: got %b expected 1101", q); end
    n_tests++; if (r !== 4'b0001) begin n_fail++; $display("FAIL 7/-2_r: got %b expected 0001", r); end
  endtask

  task automatic test_boundary;
    logic [3:0] q, r;
    int         lat;
    logic       ok;
    do_div(4'b1000, 4'b1111, q, r, lat, ok);
    n_tests++; if (q !== 4'b1000) begin n_fail++; $display("FAIL -8/-1_q: got %b expected 1000", q); end
    n_tests++; if (r !== 4'b0000) begin n_fail++; $display("FAIL -8/-1_r: got %b expected 0000", r); end
`ifdef DIV_ERR_FLAGS_EN
    n_tests++; if ({dif.o_div_by_zero, dif.o_overflow} !== 2'b01) begin n_fail++; $display("FAIL -8/-1_flags: got %b%b expected 01", dif.o_div_by_zero, dif.o_overflow); end
`endif
    do_div(4'd5, 4'd0, q, r, lat, ok);
    n_tests++; if (q !== 4'b1111) begin n_fail++; $display("FAIL 5/0_q: got %b expected 1111", q); end
    n_tests++; if (r !== 4'b0101) begin n_fail++; $display("FAIL 5/0_r: got %b expected 0101", r); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL 5/0_latency: got %0d expected 5", lat); end
`ifdef DIV_ERR_FLAGS_EN
    n_tests++; if ({dif.o_div_by_zero, dif.o_overflow} !== 2'b10) begin n_fail++; $display("FAIL 5/0_flags: got %b%b expected 10", dif.o_div_by_zero, dif.o_overflow); end
`endif
  endtask

  task automatic test_ignore_start;
    int pulses;
    pulses = 0;
    dif.start      = 1'b1;
    dif.i_dividend = 4'd6;
    dif.i_divisor  = 4'd4;
    @(posedge clk); #1;
    dif.i_dividend = 4'b1011;
    dif.i_divisor  = 4'd3;
    // start stays high through ITER, FIXUP and the DONE edge
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (dif.o_assert_done === 1'b1) pulses++;
    end
    dif.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (dif.o_assert_done === 1'b1) pulses++;
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL ignore_start_pulses: got %0d expected 1", pulses); end
    n_tests++; if (dif.o_quotient !== 4'b0001) begin n_fail++; $display("FAIL ignore_start_q: got %b expected 0001", dif.o_quotient); end
    n_tests++; if (dif.o_remainder !== 4'b0010) begin n_fail++; $display("FAIL ignore_start_r: got %b expected 0010", dif.o_remainder); end
  endtask

  task automatic test_reset_abort;
    logic [3:0] q, r;
    int         lat;
    logic       ok;
    dif.start      = 1'b1;
    dif.i_dividend = 4'd7;
    dif.i_divisor  = 4'd1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (dif.o_quotient !== 4'h0) begin n_fail++; $display("FAIL abort_q: got %h expected 0", dif.o_quotient); end
    n_tests++; if (dif.o_remainder !== 4'h0) begin n_fail++; $display("FAIL abort_r: got %h expected 0", dif.o_remainder); end
    n_tests++; if (dif.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", dif.o_busy); end
    n_tests++; if (dif.o_assert_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", dif.o_assert_done); end
    rst = 1'b0;
    do_div(4'd6, 4'd3, q, r, lat, ok);
    n_tests++; if (q !== 4'b0010) begin n_fail++; $display("FAIL 6/3_q: got %b expected 0010", q); end
    n_tests++; if (r !== 4'b0000) begin n_fail++; $display("FAIL 6/3_r: got %b expected 0000", r); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL 6/3_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_sweep;
    logic [3:0] q, r, a, b;
    logic [7:0] exp;
    int         lat;
    logic       ok;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        a = 4'(ai);
        b = 4'(bi);
        exp = model(a, b);
        do_div(a, b, q, r, lat, ok);
        n_tests++; if (q !== exp[7:4]) begin n_fail++; $display("FAIL sweep_q %h/%h: got %h expected %h", a, b, q, exp[7:4]); end
        n_tests++; if (r !== exp[3:0]) begin n_fail++; $display("FAIL sweep_r %h/%h: got %h expected %h", a, b, r, exp[3:0]); end
        n_tests++; if (lat !== 5 || ok !== 1'b1) begin n_fail++; $display("FAIL sweep_timing %h/%h: got lat %0d shape %b expected lat 5 shape 1", a, b, lat, ok); end
`ifdef DIV_ERR_FLAGS_EN
        n_tests++;
        if ({dif.o_div_by_zero, dif.o_overflow} !== {(b == 4'h0), (a == 4'h8 && b == 4'hF)}) begin
          n_fail++;
          $display("FAIL sweep_flags %h/%h: got %b%b expected %b%b", a, b, dif.o_div_by_zero, dif.o_overflow,
                   (b == 4'h0), (a == 4'h8 && b == 4'hF));
        end
`endif
      end
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    dif.start      = 1'b0;
    dif.i_dividend = 4'h0;
    dif.i_divisor  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_boundary;
    test_ignore_start;
    test_reset_abort;
    test_sweep;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
